// File: rtl/uart_tx_arbiter_pkg.sv
// uart_pkg: shared FSM state encoding and default character width for the UART transmit path
package uart_pkg;
  localparam int BITS_DEF = 8;
  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    LOAD      = 4'b0010,
    WAIT_CLR  = 4'b0100,
    WAIT_DONE = 4'b1000
  } state_t;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and transmitter-side signals of the UART transmit arbiter
interface uart_tx_arbiter_if import uart_pkg::*; #(
  parameter int BITS    = BITS_DEF,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*BITS-1:0] req_data;
  logic [NUM_REQ-1:0]      grant;
  logic [NUM_REQ-1:0]      done;
  logic [NUM_REQ-1:0]      err;
  logic [BITS-1:0]         tx_data;
  logic                    tx_data_ready;
  logic                    tx_data_sent;
  logic                    busy;
  modport master (output req, req_data, tx_data_sent,
                  input  grant, done, err, tx_data, tx_data_ready, busy);
  modport slave  (input  req, req_data, tx_data_sent,
                  output grant, done, err, tx_data, tx_data_ready, busy);
endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, searching upward from the requester after last
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int LW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [LW-1:0]      last,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);
  always_comb begin
    winner = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req[LW'((int'(last) + k) % NUM_REQ)]) winner = NUM_REQ'(1) << ((int'(last) + k) % NUM_REQ);
    valid = |req;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte requesters
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int BITS    = BITS_DEF,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096
) (
  input logic             clk,
  input logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int LW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t             state;
  logic [NUM_REQ-1:0] sel, win;
  logic [LW-1:0]      sel_idx, win_idx, last;
  logic [CW-1:0]      cnt;
  logic               valid;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (.req(bus.req), .last(last), .winner(sel), .valid(valid));
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (sel[i]) sel_idx = LW'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      bus.grant         <= '0;
      bus.done          <= '0;
      bus.err           <= '0;
      bus.tx_data_ready <= 1'b0;
      bus.busy          <= 1'b0;
      bus.tx_data       <= '0;
      cnt               <= '0;
      last              <= LW'(NUM_REQ - 1);
      win               <= '0;
      win_idx           <= '0;
    end else begin
      bus.grant         <= '0;
      bus.done          <= '0;
      bus.err           <= '0;
      bus.tx_data_ready <= 1'b0;
      case (state)
        IDLE: if (valid) begin
          bus.tx_data       <= bus.req_data[sel_idx*BITS +: BITS];
          win               <= sel;
          win_idx           <= sel_idx;
          bus.grant         <= sel;
          bus.tx_data_ready <= 1'b1;
          bus.busy          <= 1'b1;
          state             <= LOAD;
        end
        LOAD: begin
          last  <= win_idx;
          cnt   <= '0;
          state <= WAIT_CLR;
        end
        WAIT_CLR, WAIT_DONE: begin
          cnt <= cnt + 1'b1;
          // timeout wins over a data_sent seen on the same edge; cnt lands on TIMEOUT-1 and stops
          if (cnt == CW'(TIMEOUT - 2)) begin
            bus.err  <= win;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (state == WAIT_CLR && !bus.tx_data_sent) begin
            state <= WAIT_DONE;
          end else if (state == WAIT_DONE && bus.tx_data_sent) begin
            bus.done <= win;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench with a behavioural transmitter and round-robin model
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int TO = 64;
  typedef struct {
    int         kind;
    int         idx;
    logic [7:0] data;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         set_cyc = 0;
  int         model_last = NR - 1;
  exp_t       exp_q[$];
  int         mode_q[$];
  logic [7:0] dat[NR];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_tx_arbiter_if #(.BITS(8), .NUM_REQ(NR)) bus();
  uart_tx_arbiter #(.BITS(8), .NUM_REQ(NR), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic int next_rr(input int last, input logic [NR-1:0] mask);
    for (int k = 1; k <= NR; k++) if (mask[(last + k) % NR]) return (last + k) % NR;
    return 0;
  endfunction

  function automatic int onehot_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // transmitter modes: 0 normal, 1 stale data_sent high, 2 data_sent stuck low, 3 slow
  initial begin
    int m;
    bus.tx_data_sent = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.tx_data_ready) begin
        m = mode_q.size() > 0 ? mode_q.pop_front() : 0;
        if (m == 0) begin
          bus.tx_data_sent = 1'b0;
          repeat ($urandom_range(2, 10)) @(negedge clk);
          bus.tx_data_sent = 1'b1;
          set_cyc = cyc;
        end else if (m == 1) begin
          bus.tx_data_sent = 1'b1;
          repeat ($urandom_range(3, 8)) @(negedge clk);
          bus.tx_data_sent = 1'b0;
          repeat ($urandom_range(2, 6)) @(negedge clk);
          bus.tx_data_sent = 1'b1;
          set_cyc = cyc;
        end else if (m == 2) begin
          bus.tx_data_sent = 1'b0;
        end else begin
          bus.tx_data_sent = 1'b0;
          repeat (30) @(negedge clk);
          bus.tx_data_sent = 1'b1;
          set_cyc = cyc;
        end
      end
    end
  end

  initial begin
    int   gcyc;
    int   k;
    int   i;
    exp_t e;
    gcyc = 0;
    forever begin
      @(negedge clk);
      if (bus.tx_data_ready || |bus.grant) chk("ready_vs_grant", 32'(bus.tx_data_ready), 32'(|bus.grant));
      if (|{bus.grant, bus.done, bus.err}) begin
        chk("pulse_onehot", $countones({bus.grant, bus.done, bus.err}), 1);
        k = |bus.grant ? 0 : |bus.done ? 1 : 2;
        i = onehot_idx(k == 0 ? bus.grant : k == 1 ? bus.done : bus.err);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got kind %0d idx %0d, expected none", k, i);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", k, e.kind);
          chk("pulse_idx", i, e.idx);
          if (k == 0) begin
            chk("tx_data", 32'(bus.tx_data), 32'(e.data));
            chk("busy_on_grant", 32'(bus.busy), 1);
            gcyc = cyc;
          end else begin
            chk("busy_on_end", 32'(bus.busy), 0);
            if (k == 1) chk("done_latency", cyc, set_cyc + 1);
            else chk("err_latency", cyc - gcyc, TO);
          end
        end
      end
    end
  end

  function automatic int pick_mode();
    int r;
    r = $urandom_range(0, 9);
    return r < 7 ? 0 : r < 9 ? 1 : 2;
  endfunction

  task automatic session(input logic [NR-1:0] mask, input int hold_n, input int force_mode, input bit glitch);
    int   n, idx, m, g, raise_c;
    bit   fin;
    exp_t e;
    n = hold_n > 0 ? hold_n : $countones(mask);
    for (int j = 0; j < n; j++) begin
      idx = next_rr(model_last, mask);
      model_last = idx;
      m = force_mode >= 0 ? force_mode : pick_mode();
      mode_q.push_back(m);
      e.kind = 0; e.idx = idx; e.data = dat[idx];
      exp_q.push_back(e);
      e.kind = m == 2 ? 2 : 1; e.data = 8'h00;
      exp_q.push_back(e);
    end
    for (int i = 0; i < NR; i++) bus.req_data[i*8 +: 8] = dat[i];
    bus.req = mask;
    raise_c = cyc;
    g = 0;
    fin = 1'b0;
    for (int t = 0; t < 3000 && !fin; t++) begin
      @(negedge clk);
      if (|bus.grant) begin
        if (g == 0) chk("grant_latency", cyc, raise_c + 1);
        g++;
        if (hold_n == 0) bus.req = bus.req & ~bus.grant;
        else if (g == hold_n) bus.req = '0;
        if (glitch) begin
          @(negedge clk);
          bus.req[1] = 1'b1;
          @(negedge clk);
          bus.req[1] = 1'b0;
        end
      end
      fin = g >= n && exp_q.size() == 0;
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL session_timeout: got %0d grants, expected %0d", g, n);
      exp_q.delete();
      mode_q.delete();
      bus.req = '0;
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NR; i++) dat[i] = 8'($urandom);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   hold;
    bus.req = '0;
    bus.req_data = '0;
    randomize_data();
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({bus.grant, bus.done, bus.err, bus.tx_data_ready, bus.busy, bus.tx_data}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_req", 32'({bus.grant, bus.busy}), 0);

    randomize_data();
    dat[2] = 8'hA5;
    session(4'b0100, 0, 0, 1'b0);
    randomize_data();
    session(4'b1111, 8, 0, 1'b0);
    randomize_data();
    session(4'b0010, 0, 1, 1'b0);
    randomize_data();
    session(4'b0001, 0, 2, 1'b0);
    randomize_data();
    session(4'b0001, 0, 0, 1'b1);

    randomize_data();
    bus.req_data[7:0] = dat[0];
    model_last = next_rr(model_last, 4'b0001);
    e.kind = 0; e.idx = 0; e.data = dat[0];
    exp_q.push_back(e);
    mode_q.push_back(3);
    bus.req = 4'b0001;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (|bus.grant) break;
    end
    bus.req = '0;
    repeat (6) @(negedge clk);
    chk("rst_abort_granted", exp_q.size(), 0);
    chk("busy_before_rst", 32'(bus.busy), 1);
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last = NR - 1;
    chk("rst_mid_outputs", 32'({bus.grant, bus.done, bus.err, bus.tx_data_ready, bus.busy, bus.tx_data}), 0);
    repeat (40) @(negedge clk);
    randomize_data();
    session(4'b1000, 0, 0, 1'b0);

    for (int s = 0; s < 30; s++) begin
      randomize_data();
      hold = $urandom_range(0, 3) == 0 ? int'($urandom_range(2, 6)) : 0;
      session(NR'($urandom_range(1, 15)), hold, -1, 1'b0);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
